// File: rtl/game_link_uart.sv
// game_link_uart: board-to-board serial link for the two-player duck game.
// Exchanges 2-byte frames (header, payload) over an 8N1 UART. Everything is
// clocked by pclk.
//   START frame : HDR_START, 8'h00          -> peer is ready to play
//   SCORE frame : HDR_SCORE, {1'b0, score}  -> peer's score (0..99)
// Ports:
//   pclk              pixel clock
//   rst               asynchronous active-low reset
//   rect_clicked_play 1-cycle pulse, local PLAY click (send START, local ready)
//   state[1:0]        game state; entering SCORE_STATE sends a SCORE frame
//   my_score[6:0]     local score, sampled when the SCORE frame starts
//   rx                serial in from peer (asynchronous)
//   tx                serial out to peer
//   uart_start        1-cycle pulse when both sides are ready
//   op_score[6:0]     last valid score received from the peer
//   link_err          sticky error flag (framing error or bad payload)
module game_link_uart #(
    parameter int         CLKS_PER_BIT = 651,
    parameter logic [1:0] SCORE_STATE  = 2'b11,
    parameter logic [7:0] HDR_START    = 8'hA5,
    parameter logic [7:0] HDR_SCORE    = 8'h5A
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       rect_clicked_play,
    input  logic [1:0] state,
    input  logic [6:0] my_score,
    input  logic       rx,
    output logic       tx,
    output logic       uart_start,
    output logic [6:0] op_score,
    output logic       link_err
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------ rx sync
    // rx_prev is a third stage used only for falling-edge detection.
    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) {rx_s1, rx_s2, rx_prev} <= 3'b111;
        else      {rx_s1, rx_s2, rx_prev} <= {rx, rx_s1, rx_s2};
    end

    // ------------------------------------------------------------ rx byte FSM
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t     rx_st, rx_nx;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_good, rx_ferr, byte_valid;

    always_comb begin
        rx_nx   = rx_st;
        rx_good = 1'b0;
        rx_ferr = 1'b0;
        case (rx_st)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_nx = RX_START;
            // mid start bit: a line back at 1 means it was only a glitch
            RX_START: if (rx_cnt == HALF_LAST) rx_nx = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_nx = RX_STOP;
            RX_STOP:  if (rx_cnt == BIT_LAST) begin
                rx_nx   = RX_IDLE;
                rx_good = rx_s2;
                rx_ferr = !rx_s2;
            end
            default:  rx_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            rx_st      <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_st      <= rx_nx;
            byte_valid <= rx_good;
            // counter restarts at the half-bit point so later samples land mid-bit
            if (rx_st == RX_IDLE || (rx_st == RX_START && rx_cnt == HALF_LAST) ||
                rx_cnt == BIT_LAST)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_st == RX_START) begin
                rx_bit <= '0;
            end else if (rx_st == RX_DATA && rx_cnt == BIT_LAST) begin
                rx_bit <= rx_bit + 3'd1;
                rx_sh  <= {rx_s2, rx_sh[7:1]};
            end
        end
    end

    // ------------------------------------------------------------ frame FSM
    typedef enum logic {R_HDR, R_PAY} fr_state_t;
    fr_state_t fr_st, fr_nx;
    logic      fr_score;     // 1: current frame is SCORE, 0: START
    logic      remote_set, score_set, err_set;

    always_comb begin
        fr_nx      = fr_st;
        remote_set = 1'b0;
        score_set  = 1'b0;
        err_set    = rx_ferr;
        if (rx_ferr) begin
            fr_nx = R_HDR;
        end else if (byte_valid) begin
            case (fr_st)
                R_HDR: if (rx_sh == HDR_START || rx_sh == HDR_SCORE) fr_nx = R_PAY;
                R_PAY: begin
                    fr_nx = R_HDR;
                    if (!fr_score) begin
                        remote_set = (rx_sh == 8'h00);
                        err_set    = (rx_sh != 8'h00);
                    end else begin
                        score_set = !rx_sh[7] && (rx_sh[6:0] <= 7'd99);
                        err_set   = !score_set;
                    end
                end
                default: fr_nx = R_HDR;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            fr_st    <= R_HDR;
            fr_score <= 1'b0;
            op_score <= '0;
            link_err <= 1'b0;
        end else begin
            fr_st <= fr_nx;
            if (byte_valid && fr_st == R_HDR) fr_score <= (rx_sh == HDR_SCORE);
            if (score_set) op_score <= rx_sh[6:0];
            if (err_set)   link_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------ handshake
    logic local_ready, remote_ready;
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            local_ready  <= 1'b0;
            remote_ready <= 1'b0;
            uart_start   <= 1'b0;
        end else if (local_ready && remote_ready) begin
            uart_start   <= 1'b1;
            local_ready  <= 1'b0;
            remote_ready <= 1'b0;
        end else begin
            uart_start <= 1'b0;
            if (rect_clicked_play) local_ready  <= 1'b1;
            if (remote_set)        remote_ready <= 1'b1;
        end
    end

    // ------------------------------------------------------------ tx path
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY} tx_state_t;
    tx_state_t     tx_st, tx_nx;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;       // 0 = start bit, 9 = stop bit
    logic [9:0]    tx_sh;        // {stop, data, start}; bit 0 drives the line
    logic [7:0]    tx_pay;
    logic [1:0]    state_q;
    logic          start_req, score_req, tx_last, tx_go;

    assign tx      = tx_sh[0];
    assign tx_last = (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
    // a pending frame starts straight after the previous stop bit, no gap
    assign tx_go   = (tx_st == T_IDLE || (tx_st == T_PAY && tx_last)) &&
                     (start_req || score_req);

    always_comb begin
        tx_nx = tx_st;
        case (tx_st)
            T_IDLE:  if (tx_go) tx_nx = T_HDR;
            T_HDR:   if (tx_last) tx_nx = T_PAY;
            T_PAY:   if (tx_last) tx_nx = tx_go ? T_HDR : T_IDLE;
            default: tx_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            tx_st     <= T_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '1;
            tx_pay    <= '0;
            state_q   <= '0;
            start_req <= 1'b0;
            score_req <= 1'b0;
        end else begin
            tx_st   <= tx_nx;
            state_q <= state;

            // START wins when both are pending; each request clears as its frame begins
            if (tx_go && start_req)  start_req <= 1'b0;
            if (tx_go && !start_req) score_req <= 1'b0;
            if (rect_clicked_play)   start_req <= 1'b1;
            if (state == SCORE_STATE && state_q != SCORE_STATE) score_req <= 1'b1;

            if (tx_go) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                tx_sh  <= {1'b1, (start_req ? HDR_START : HDR_SCORE), 1'b0};
                tx_pay <= start_req ? 8'h00 : {1'b0, my_score};
            end else if (tx_st != T_IDLE) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_bit <= '0;
                        tx_sh  <= (tx_st == T_HDR) ? {1'b1, tx_pay, 1'b0} : '1;
                    end else begin
                        tx_bit <= tx_bit + 4'd1;
                        tx_sh  <= {1'b1, tx_sh[9:1]};
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_link_uart.sv
// Bench for game_link_uart at CLKS_PER_BIT=16. A behavioural UART receiver
// decodes tx into byte/timestamp queues; rx is driven bit by bit.
module tb_game_link_uart;
    localparam int CPB = 16;

    logic       pclk = 1'b0, rst = 1'b0, click = 1'b0, rx = 1'b1;
    logic [1:0] state = 2'b00;
    logic [6:0] my_score = 7'd0;
    logic       tx, uart_start, link_err;
    logic [6:0] op_score;

    game_link_uart #(.CLKS_PER_BIT(CPB)) dut (
        .pclk(pclk), .rst(rst), .rect_clicked_play(click), .state(state),
        .my_score(my_score), .rx(rx), .tx(tx), .uart_start(uart_start),
        .op_score(op_score), .link_err(link_err));

    always #5 pclk = ~pclk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, us_cnt = 0;
    always @(posedge pclk) cyc <= cyc + 1;
    always @(posedge pclk) if (uart_start) us_cnt <= us_cnt + 1;

    typedef logic [7:0] bq_t [$];
    logic [7:0] txb_q [$];
    logic       txs_q [$];
    int         txt_q [$];

    // peer-side receiver: samples each of the 10 bits at its midpoint
    initial begin : tx_mon
        int n;
        int t0;
        logic [9:0] fr;
        n = -1; t0 = 0; fr = '0;
        forever begin
            @(negedge pclk);
            if (!rst) n = -1;
            else if (n < 0) begin
                if (!tx) begin n = 0; t0 = cyc; end
            end else begin
                n++;
                if (n % CPB == CPB / 2) begin
                    fr[n / CPB] = tx;
                    if (n / CPB == 9) begin
                        txb_q.push_back(fr[8:1]);
                        txs_q.push_back(fr[9]);
                        txt_q.push_back(t0);
                        n = -1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", n_tests);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic clear_q();
        txb_q.delete(); txs_q.delete(); txt_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0; click = 1'b0; rx = 1'b1; state = 2'b00;
        tick(3);
        clear_q();
        rst = 1'b1;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
        rx = stop; tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_q(input bq_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
        tick(4);
    endtask

    // click and expect uart_start exactly on the second cycle after, or never
    task automatic click_check(input string name, input logic exp);
        logic u1, u2, u3;
        int   base;
        click = 1'b1; tick(1);
        click = 1'b0; u1 = uart_start; tick(1);
        u2 = uart_start; tick(1);
        u3 = uart_start;
        base = us_cnt;
        tick(4);
        chk(name, {28'd0, u1, u2, u3, 1'b0} | 32'(us_cnt != base), {28'd0, 1'b0, exp, 1'b0, 1'b0});
    endtask

    task automatic wait_tx(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (txb_q.size() < n && k < budget) begin tick(1); k++; end
        chk(name, 32'(txb_q.size() >= n), 32'd1);
    endtask

    function automatic void model(input bq_t q, output logic [6:0] op,
                                  output logic err, output logic rdy);
        int i;
        logic [7:0] h, p;
        op = '0; err = 1'b0; rdy = 1'b0; i = 0;
        while (i < q.size()) begin
            h = q[i];
            if ((h == 8'hA5 || h == 8'h5A) && i + 1 < q.size()) begin
                p = q[i + 1];
                if (h == 8'hA5) begin
                    if (p == 8'h00) rdy = 1'b1; else err = 1'b1;
                end else if (p <= 8'd99) op = p[6:0];
                else err = 1'b1;
                i += 2;
            end else i += 1;
        end
    endfunction

    // RX vectors: up to 4 bytes, first byte in bits [7:0]
    typedef struct packed {
        logic [2:0]  nb;
        logic [31:0] b;
        logic [6:0]  op;
        logic        err;
        logic        rdy;
    } vec_t;

    function automatic vec_t mk(input int nb, input logic [31:0] b, input int op,
                                input logic err, input logic rdy);
        mk = {3'(nb), b, 7'(op), err, rdy};
    endfunction

    initial begin : main
        vec_t       vt [10];
        bq_t        q;
        logic [6:0] mop;
        logic       merr, mrdy;
        logic       a, b;
        logic [7:0] bv;
        int         base;

        vt[0] = mk(2, 32'h00002A5A, 42, 1'b0, 1'b0);
        vt[1] = mk(4, 32'h645A2A5A, 42, 1'b1, 1'b0);  // 100 rejected, 42 kept
        vt[2] = mk(3, 32'h0000A5C3,  0, 1'b0, 1'b1);  // stray C3 ignored
        vt[3] = mk(2, 32'h000001A5,  0, 1'b1, 1'b0);  // START with nonzero payload
        vt[4] = mk(2, 32'h0000635A, 99, 1'b0, 1'b0);  // upper bound
        vt[5] = mk(2, 32'h0000E35A,  0, 1'b1, 1'b0);  // bit7 set
        vt[6] = mk(3, 32'h002A5AA5,  0, 1'b1, 1'b0);  // header value as START payload
        vt[7] = mk(4, 32'h00A500A5,  0, 1'b0, 1'b1);  // repeated START
        vt[8] = mk(4, 32'h005A075A,  0, 1'b0, 1'b0);  // lower bound after 7
        vt[9] = mk(3, 32'h002D5A5A, 90, 1'b0, 1'b0);  // 5A as SCORE payload = 90

        // reset state
        do_reset();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_uart_start", 32'(uart_start), 32'd0);
        chk("rst_op_score", 32'(op_score), 32'd0);
        chk("rst_link_err", 32'(link_err), 32'd0);

        // table-driven RX frames
        for (int v = 0; v < 10; v++) begin
            do_reset();
            q.delete();
            for (int i = 0; i < int'(vt[v].nb); i++) q.push_back(vt[v].b[8*i +: 8]);
            send_q(q);
            chk($sformatf("vec%0d_op", v), 32'(op_score), 32'(vt[v].op));
            chk($sformatf("vec%0d_err", v), 32'(link_err), 32'(vt[v].err));
            click_check($sformatf("vec%0d_rdy", v), vt[v].rdy);
        end

        // START frame on tx: latency, bytes, timing
        do_reset();
        base = us_cnt;
        click = 1'b1; tick(1);
        click = 1'b0; a = tx; tick(1);
        b = tx;
        chk("t1_latency", {30'd0, a, b}, 32'b10);
        wait_tx("t1_wait", 2, 25 * CPB);
        chk("t1_hdr", 32'(txb_q[0]), 32'hA5);
        chk("t1_pay", 32'(txb_q[1]), 32'h00);
        chk("t1_stops", {30'd0, txs_q[0], txs_q[1]}, 32'b11);
        chk("t1_gap", 32'(txt_q[1] - txt_q[0]), 32'(10 * CPB));
        tick(12 * CPB);
        chk("t1_nomore", 32'(txb_q.size()), 32'd2);
        chk("t1_no_start", 32'(us_cnt - base), 32'd0);

        // handshake: remote first, click later; then flags cleared
        do_reset();
        q = '{8'hA5, 8'h00};
        send_q(q);
        tick(50);
        click_check("hs_pulse", 1'b1);
        click_check("hs_cleared", 1'b0);

        // handshake: local first, remote later -> exactly one pulse
        do_reset();
        base = us_cnt;
        click = 1'b1; tick(1); click = 1'b0;
        send_q(q);
        tick(8);
        chk("hs_local_first", 32'(us_cnt - base), 32'd1);

        // SCORE send on entering SCORE_STATE, nothing more while held
        do_reset();
        my_score = 7'd37; state = 2'b01; tick(2);
        state = 2'b11;
        wait_tx("t3_wait", 2, 25 * CPB);
        chk("t3_hdr", 32'(txb_q[0]), 32'h5A);
        chk("t3_pay", 32'(txb_q[1]), 32'h25);
        tick(25 * CPB);
        chk("t3_held", 32'(txb_q.size()), 32'd2);

        // framing error drops the byte
        do_reset();
        send_byte(8'h5A, 1'b0);
        tick(2 * CPB);
        chk("t5_ferr", 32'(link_err), 32'd1);
        send_byte(8'h2A, 1'b1); tick(4);
        chk("t5_dropped", 32'(op_score), 32'd0);

        // 3-cycle glitch must not swallow the following frame
        do_reset();
        rx = 1'b0; tick(3); rx = 1'b1; tick(CPB);
        q = '{8'h5A, 8'h2A};
        send_q(q);
        chk("t5_glitch_op", 32'(op_score), 32'd42);
        chk("t5_glitch_err", 32'(link_err), 32'd0);

        // SCORE request during START frame, score captured at frame start
        do_reset();
        my_score = 7'd11;
        click = 1'b1; tick(1); click = 1'b0;
        tick(3 * CPB);
        state = 2'b01; tick(1); state = 2'b11;
        tick(2 * CPB);
        my_score = 7'd77;
        wait_tx("t6_wait", 4, 45 * CPB);
        chk("t6_bytes", {txb_q[0], txb_q[1], txb_q[2], txb_q[3]}, 32'hA5005A4D);
        chk("t6_b2b", 32'(txt_q[2] - txt_q[0]), 32'(20 * CPB));

        // reset mid-byte
        do_reset();
        send_byte(8'h00, 1'b0); tick(CPB);
        q = '{8'h5A, 8'h2A};
        send_q(q);
        click = 1'b1; tick(1); click = 1'b0;
        tick(5 * CPB);
        rst = 1'b0;
        #1;
        chk("t6_rst_out", {23'd0, tx, uart_start, op_score, link_err}, {23'd0, 1'b1, 1'b0, 7'd0, 1'b0});
        tick(3);
        rst = 1'b1;
        tick(12 * CPB);
        clear_q();
        click = 1'b1; tick(1); click = 1'b0;
        wait_tx("t6_post_wait", 2, 25 * CPB);
        chk("t6_post_bytes", {16'd0, txb_q[0], txb_q[1]}, 32'h0000A500);

        // randomized RX byte streams vs frame model
        for (int it = 0; it < 15; it++) begin
            do_reset();
            q.delete();
            for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
                case ($urandom_range(0, 5))
                    0: bv = 8'hA5;
                    1: bv = 8'h5A;
                    2: bv = 8'h00;
                    3: bv = 8'($urandom_range(0, 99));
                    4: bv = 8'($urandom_range(100, 255));
                    default: bv = 8'($urandom);
                endcase
                q.push_back(bv);
            end
            send_q(q);
            model(q, mop, merr, mrdy);
            chk($sformatf("rnd%0d_op", it), 32'(op_score), 32'(mop));
            chk($sformatf("rnd%0d_err", it), 32'(link_err), 32'(merr));
            click_check($sformatf("rnd%0d_rdy", it), mrdy);
        end

        // randomized SCORE sends
        for (int it = 0; it < 6; it++) begin
            do_reset();
            my_score = 7'($urandom_range(0, 99));
            state = 2'($urandom_range(0, 2));
            tick(2);
            state = 2'b11;
            wait_tx($sformatf("rtx%0d_wait", it), 2, 25 * CPB);
            chk($sformatf("rtx%0d_frame", it), {16'd0, txb_q[0], txb_q[1]},
                {16'd0, 8'h5A, 1'b0, my_score});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_link_uart.md
Name: game_link_uart

Overview:
- Board-to-board serial link for the two-player duck game.
- Sits upstream of the game state machine and the score compare/ASCII path, and produces `uart_start` and `op_score`.
- Consumes the local play click, game state and local score, and sends them to the peer board as 2-byte frames over a UART at 8N1.
- Contains its own serializer, deserializer and framing FSMs, all clocked by `pclk`.

Parameters:
- CLKS_PER_BIT, 651, pclk cycles per UART bit (75 MHz / 115200); minimum 4.
- SCORE_STATE, 2'b11, `state` encoding of the score screen; entering it triggers a score send.
- HDR_START, 8'hA5, header byte of a START frame.
- HDR_SCORE, 8'h5A, header byte of a SCORE frame.

Ports:
- pclk  in  1  pixel clock; every register in this block is clocked by it.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rect_clicked_play  in  1  one-cycle pulse: local player clicked PLAY.
- state  in  2  current game state from the state machine.
- my_score  in  7  local score, 0..99.
- rx  in  1  serial input from the peer; asynchronous to pclk.
- tx  out  1  serial output to the peer.
- uart_start  out  1  one-cycle pulse: both players are ready.
- op_score  out  7  last valid score received from the peer.
- link_err  out  1  sticky error flag.

Behaviour:

Reset values:
- tx=1, uart_start=0, op_score=0, link_err=0.
- All FSMs in idle, all flags and requests cleared.
- The rx synchronizer flops reset to 1.
- Reset asserted mid-byte aborts immediately; tx returns to 1 on the same reset edge.

RX path:
- rx passes through a 2-FF synchronizer.
- A falling edge while the RX FSM is in idle starts a byte. The line is re-checked at CLKS_PER_BIT/2; if it reads 1, this is a glitch and the FSM returns to idle.
- 8 data bits are sampled LSB first at mid-bit, every CLKS_PER_BIT cycles. The stop bit is sampled at mid-bit.
- Stop bit = 0 is a framing error: set link_err, drop the byte, and the frame FSM returns to R_HDR.
- A good byte produces an internal byte_valid pulse one cycle after the stop-bit sample.

Frame FSM (R_HDR, R_PAY):
- R_HDR: a byte equal to HDR_START or HDR_SCORE stores the frame type and moves to R_PAY. Any other byte is ignored silently.
- R_PAY, START frame: payload must be 8'h00. If so, set remote_ready; otherwise set link_err. Return to R_HDR either way.
- R_PAY, SCORE frame: payload must have bit7=0 and value ≤99. If so, op_score <= payload[6:0] in the cycle after byte_valid; otherwise set link_err and keep op_score unchanged. Return to R_HDR either way.
- In R_PAY any byte, including a header value, is treated as payload.

TX path:
- start_req is set by rect_clicked_play.
- score_req is set on the cycle `state` changes from any value to SCORE_STATE.
- The `my_score` value to send is captured when the score frame begins, not when score_req is set.
- A request arriving during a transmission stays pending and is sent after the current frame.
- If both requests are pending, START is sent first.
- TX FSM: T_IDLE -> T_HDR -> T_PAY -> T_IDLE. Each byte is start bit 0, 8 data bits LSB first, stop bit 1, each bit held for CLKS_PER_BIT cycles.
- The header and payload bytes go back to back, with no idle gap. A frame is 20*CLKS_PER_BIT cycles.
- A request is cleared when its frame begins.
- The first start bit appears on tx 1 cycle after the request is set, when TX is idle.

Handshake:
- local_ready is set by rect_clicked_play.
- When local_ready && remote_ready, uart_start pulses for exactly 1 cycle, on the cycle after the second flag sets. Both flags clear on that same cycle.
- If both flags set in the same cycle, uart_start pulses on the next cycle.
- Repeated clicks or START frames while a flag is already set have no additional effect.

Error flag:
- link_err stays at 1 until reset.
- RX and TX are full duplex and independent.

Test Plan:
1. CLKS_PER_BIT=16: pulse rect_clicked_play -> tx emits bytes A5, 00 (bit pattern 0,1010 0101 LSB-first,1), 320 cycles total; uart_start stays 0.
2. rx loopback frame A5,00, then rect_clicked_play 50 cycles later -> uart_start high for exactly 1 cycle, the cycle after the click; both flags cleared (a second click gives no pulse).
3. my_score=37, state 2'b01 -> SCORE_STATE -> tx sends 5A, 25; a held SCORE_STATE sends nothing more. Incoming 5A, 2A -> op_score=42 one cycle after the stop-bit sample.
4. Incoming 5A, 64 (100) -> link_err=1, op_score keeps 42. Then incoming byte C3 then A5, 00 -> C3 ignored, remote_ready set.
5. Byte with stop bit 0 -> link_err=1, byte dropped. A 3-cycle low glitch on rx -> no byte received.
6. Score request raised while a START frame is sending -> the SCORE frame follows immediately after. rst=0 mid-byte -> tx=1, outputs reset, then clean operation after rst=1.
